// File: rtl/adc_pkg.sv
// Shared definitions for the thermometer-code ADC sampler: FSM encoding,
// synchroniser depth and a constant-foldable ceil(log2) helper.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_ACCUM = 2'd2
  } state_e;

  // Flops in the comparator synchroniser; also the SYNC flush length.
  localparam int unsigned SYNC_DEPTH = 2;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(value)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_thermo_encoder.sv
// Combinational thermometer-to-binary encoder with 3-input majority bubble
// correction.
//   t     : synchronised comparator word, bit 0 = lowest threshold
//   code  : popcount of the corrected word, 0..N_LEVELS
//   valid : 1 when t is a clean thermometer word (0...01...1)
module adc_thermo_encoder
  import adc_pkg::*;
#(
  parameter  int unsigned N_LEVELS = 15,
  localparam int unsigned OUT_W    = clog2(N_LEVELS + 1)
) (
  input  logic [N_LEVELS-1:0] t,
  output logic [OUT_W-1:0]    code,
  output logic                valid
);

  logic [N_LEVELS+1:0] ext;
  logic [N_LEVELS-1:0] c;

  // Pad with an implied 1 below bit 0 and an implied 0 above the top bit,
  // then take the majority of each bit and its two neighbours.
  always_comb begin
    ext  = {1'b0, t, 1'b1};
    c    = '0;
    code = '0;
    for (int i = 0; i < int'(N_LEVELS); i++) begin
      c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
      code = code + OUT_W'(c[i]);
    end
  end

  // A set bit sitting directly above a clear bit breaks the thermometer form.
  assign valid = ~|(t[N_LEVELS-1:1] & ~t[N_LEVELS-2:0]);

endmodule

// File: rtl/adc_thermo_sampler.sv
// Flash-ADC sampler: synchronises the comparator thermometer word, bubble
// corrects and encodes it, averages 2^AVG_LOG2 samples per window and
// strobes the result. Single-shot or continuous windows.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : request a window (honoured only when idle)
//   continuous   : repeat windows back-to-back while high
//   comp_in      : raw asynchronous comparator outputs
//   busy         : not idle
//   data_out     : averaged code, held between results
//   data_valid   : one-cycle strobe with each data_out update
//   bubble_err   : sticky non-thermometer flag, cleared on accepted start
module adc_thermo_sampler
  import adc_pkg::*;
#(
  parameter  int unsigned N_LEVELS = 15,
  parameter  int unsigned AVG_LOG2 = 2,
  localparam int unsigned OUT_W    = clog2(N_LEVELS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [N_LEVELS-1:0] comp_in,
  output logic                busy,
  output logic [OUT_W-1:0]    data_out,
  output logic                data_valid,
  output logic                bubble_err
);

  localparam int unsigned ACC_W    = OUT_W + AVG_LOG2;
  localparam int unsigned CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned CNT_LAST = (1 << AVG_LOG2) - 1;
  localparam int unsigned SCNT_W   = (clog2(SYNC_DEPTH) > 0) ? clog2(SYNC_DEPTH) : 1;

  logic [N_LEVELS-1:0] sync1_q, sync2_q;
  state_e              state_q, state_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                bubble_q, bubble_d;
  logic                busy_q, busy_d;

  logic [OUT_W-1:0]    code_c;
  logic                tvalid_c;
  logic                last_c;
  logic [ACC_W-1:0]    acc_sum_c;

  adc_thermo_encoder #(
    .N_LEVELS (N_LEVELS)
  ) u_enc (
    .t     (sync2_q),
    .code  (code_c),
    .valid (tvalid_c)
  );

  assign last_c    = (cnt_q == CNT_W'(CNT_LAST));
  assign acc_sum_c = acc_q + ACC_W'(code_c);

  // Two-flop synchroniser for the asynchronous comparator word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= comp_in;
      sync2_q <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      scnt_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    bubble_d = bubble_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SYNC;
          scnt_d   = '0;
          cnt_d    = '0;
          acc_d    = '0;
          bubble_d = 1'b0;
        end
      end
      // Flush whatever the synchroniser held before the window began.
      ST_SYNC: begin
        if (scnt_q == SCNT_W'(SYNC_DEPTH - 1)) begin
          scnt_d  = '0;
          state_d = ST_ACCUM;
        end else begin
          scnt_d  = SCNT_W'(scnt_q + 1'b1);
        end
      end
      ST_ACCUM: begin
        if (!tvalid_c) bubble_d = 1'b1;
        if (last_c) begin
          data_d  = OUT_W'(acc_sum_c >> AVG_LOG2);
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = continuous ? ST_ACCUM : ST_IDLE;
        end else begin
          acc_d   = acc_sum_c;
          cnt_d   = CNT_W'(cnt_q + 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign busy       = busy_q;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign bubble_err = bubble_q;

endmodule

// File: tb/tb_adc_thermo_sampler.sv
// Self-checking bench for adc_thermo_sampler at default parameters.
module tb_adc_thermo_sampler;

  localparam int N    = 15;
  localparam int A    = 2;
  localparam int NS   = 1 << A;
  localparam int OW   = 4;
  localparam int MAXE = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          continuous;
  logic [N-1:0]  comp_in;
  logic          busy;
  logic [OW-1:0] data_out;
  logic          data_valid;
  logic          bubble_err;

  adc_thermo_sampler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .continuous (continuous),
    .comp_in    (comp_in),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bubble_err (bubble_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_data = 0;
  bit exp_bub  = 1'b0;

  // stim[k] is the comparator word present at clock edge Ek of a window.
  logic [N-1:0] stim [0:MAXE-1];

  typedef struct {
    logic [N-1:0] comp;
    int           code;
    bit           bub;
  } vec_t;

  vec_t tbl [0:9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Corrected code: each bit is the majority of itself and its neighbours,
  // with a 1 implied below bit 0 and a 0 implied above the top bit.
  function automatic int ref_code(input logic [N-1:0] w);
    int n, lo, hi, mid;
    n = 0;
    for (int i = 0; i < N; i++) begin
      lo  = (i == 0)     ? 1 : int'(w[i-1]);
      hi  = (i == N - 1) ? 0 : int'(w[i+1]);
      mid = int'(w[i]);
      if (lo + mid + hi >= 2) n++;
    end
    return n;
  endfunction

  // A clean thermometer word equals 2^ones - 1.
  function automatic bit ref_valid(input logic [N-1:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) ones += int'(w[i]);
    return int'(w) == ((1 << ones) - 1);
  endfunction

  function automatic logic [N-1:0] gen_word();
    int           sel, lvl;
    logic [N:0]   tmp;
    logic [N-1:0] w;
    sel = $urandom_range(0, 3);
    lvl = $urandom_range(0, N);
    tmp = (17'(1) << lvl) - 1;
    w   = tmp[N-1:0];
    if (sel == 2) w = w ^ N'(1 << $urandom_range(0, N - 1));
    if (sel == 3) w = N'($urandom);
    return w;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_busy",   int'(busy), 0);
      check("idle_valid",  int'(data_valid), 0);
      check("idle_data",   int'(data_out), exp_data);
      check("idle_bubble", int'(bubble_err), int'(exp_bub));
    end
  endtask

  // Runs nwin windows from stim[]; continuous is held until the last window.
  // poke_edge (if nonzero) pulses start at that edge while the block is busy.
  task automatic run(input int nwin, input int poke_edge);
    int last_e, sum;
    bit vexp;
    last_e     = 2 + NS * nwin;
    exp_bub    = 1'b0;
    start      = 1'b1;
    continuous = (nwin > 1);
    comp_in    = stim[0];
    for (int k = 0; k <= last_e + 2; k++) begin
      @(posedge clk); #1;
      if (k >= 3 && k <= last_e && !ref_valid(stim[k-2])) exp_bub = 1'b1;
      vexp = (k >= 2 + NS) && (k <= last_e) && ((k - 2) % NS == 0);
      if (vexp) begin
        sum = 0;
        for (int m = k - NS + 1; m <= k; m++) sum += ref_code(stim[m-2]);
        exp_data = sum >> A;
      end
      check("busy",   int'(busy), int'(k < last_e));
      check("valid",  int'(data_valid), int'(vexp));
      check("data",   int'(data_out), exp_data);
      check("bubble", int'(bubble_err), int'(exp_bub));
      start      = ((k + 1) == poke_edge);
      continuous = ((k + 1) < last_e);
      comp_in    = (k + 1 < MAXE) ? stim[k+1] : '0;
    end
    start      = 1'b0;
    continuous = 1'b0;
  endtask

  task automatic fill(input logic [N-1:0] w);
    for (int i = 0; i < MAXE; i++) stim[i] = w;
  endtask

  initial begin
    tbl[0] = '{15'h0000,  0, 1'b0};
    tbl[1] = '{15'h0001,  1, 1'b0};
    tbl[2] = '{15'h007F,  7, 1'b0};
    tbl[3] = '{15'h7FFF, 15, 1'b0};
    tbl[4] = '{15'h005F,  6, 1'b1};
    tbl[5] = '{15'h3FFF, 14, 1'b0};
    tbl[6] = '{15'h0002,  1, 1'b1};
    tbl[7] = '{15'h4000,  0, 1'b1};
    tbl[8] = '{15'h7FFE, 15, 1'b1};
    tbl[9] = '{15'h0055,  4, 1'b1};

    reset_n    = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;
    comp_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   int'(busy), 0);
    check("rst_valid",  int'(data_valid), 0);
    check("rst_data",   int'(data_out), 0);
    check("rst_bubble", int'(bubble_err), 0);
    reset_n = 1'b1;
    idle(2);

    // Static single-shot windows from the vector table.
    for (int v = 0; v < 10; v++) begin
      fill(tbl[v].comp);
      run(1, 0);
      check("tbl_data",   int'(data_out), tbl[v].code);
      check("tbl_bubble", int'(bubble_err), int'(tbl[v].bub));
      idle(2);
    end

    // Truncation: codes 3,4,4,4 sum to 15, averaged down to 3.
    fill('0);
    stim[1] = 15'h0007;
    stim[2] = 15'h000F;
    stim[3] = 15'h000F;
    stim[4] = 15'h000F;
    run(1, 0);
    check("trunc_data", int'(data_out), 3);
    idle(1);

    // Bubble stays sticky while idle, then clears on a clean start.
    fill(15'h005F);
    run(1, 0);
    idle(3);
    check("bub_sticky", int'(bubble_err), 1);
    fill(15'h00FF);
    run(1, 0);
    check("bub_clear", int'(bubble_err), 0);
    check("bub_clear_data", int'(data_out), 8);

    // Continuous: three back-to-back windows then continuous drops.
    fill(15'h7FFF);
    run(4, 0);
    check("cont_data", int'(data_out), 15);
    idle(2);

    // Starts while busy must be ignored, including on the final edge.
    fill('0);
    run(1, 3);
    check("ign_data", int'(data_out), 0);
    fill('0);
    run(1, 6);
    check("ign_last_data", int'(data_out), 0);
    idle(2);

    // Continuous run with a start poke mid-stream.
    fill(15'h0FFF);
    run(3, 9);
    check("cont_poke_data", int'(data_out), 12);
    idle(1);

    // Randomised windows against the reference model.
    for (int r = 0; r < 25; r++) begin
      int nw, pk;
      for (int i = 0; i < MAXE; i++) stim[i] = gen_word();
      nw = $urandom_range(1, 4);
      pk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 + NS * nw) : 0;
      run(nw, pk);
      idle($urandom_range(1, 3));
    end

    // Reset during accumulation aborts the window with no strobe.
    start      = 1'b1;
    continuous = 1'b0;
    comp_in    = 15'h005F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy",   int'(busy), 1);
    check("pre_rst_bubble", int'(bubble_err), 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy",   int'(busy), 0);
    check("arst_valid",  int'(data_valid), 0);
    check("arst_data",   int'(data_out), 0);
    check("arst_bubble", int'(bubble_err), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    exp_data = 0;
    exp_bub  = 1'b0;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_thermo_sampler.md
# adc_thermo_sampler

Parametrised successor to the 4-comparator flash-ADC encoder in the ADC digital control path. It synchronises an N-level comparator thermometer word and applies bubble correction. It converts the corrected word to binary, averages 2^AVG_LOG2 consecutive samples, and presents the result with a one-cycle valid strobe. It supports single-shot and continuous conversion, and flags non-monotonic comparator codes.

## Interface
Parameters:
- N_LEVELS, 15: number of comparator outputs (thermometer bits), ≥2.
- AVG_LOG2, 2: log2 of samples averaged per result, 0..8.
- OUT_W, clog2(N_LEVELS+1): derived, result width; not overridden.

Ports:
- clk  input  1  single system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request one conversion window; accepted only in IDLE.
- continuous  input  1  when 1, windows repeat back-to-back.
- comp_in  input  N_LEVELS  raw comparator outputs, asynchronous to clk; bit 0 = lowest threshold.
- busy  output  1  high in any state other than IDLE.
- data_out  output  OUT_W  averaged code; holds its value between results.
- data_valid  output  1  one-cycle strobe when data_out updates.
- bubble_err  output  1  sticky: a non-thermometer word was seen in the current or last window.

## Operation
- Synchroniser: comp_in passes through two flops (sync1, sync2). Only sync2 is used downstream.
- Bubble correction, per bit i: c[i] = majority(t[i-1], t[i], t[i+1]), with t[-1]=1 and t[N_LEVELS]=0. t is sync2.
- Code: popcount(c), range 0..N_LEVELS. This matches the legacy map (0001→1 one … 1111→4 ones).
- Validity: t is valid iff it has the form 0…01…1, including all-0 and all-1. An invalid t during ACCUM sets bubble_err.
- FSM states: IDLE, SYNC, ACCUM.
  - IDLE→SYNC on start=1. This edge clears acc, sample counter and bubble_err.
  - SYNC runs 2 cycles to flush stale synchroniser contents, then goes to ACCUM.
  - ACCUM: each cycle acc += code and the counter increments.
- Last sample of a window (counter = 2^AVG_LOG2−1):
  - data_out <= (acc + code) >> AVG_LOG2, truncating.
  - data_valid <= 1.
  - acc and counter clear.
  - Next state is ACCUM if continuous=1 at that edge, else IDLE.
- Accumulator width: OUT_W+AVG_LOG2. No overflow is possible.
- start is ignored while busy. continuous dropping mid-window completes the current window.
- bubble_err clears only on an accepted start. It stays sticky across continuous windows.

## Timing
- Reset: state=IDLE; sync flops, acc, counter = 0; busy=0, data_out=0, data_valid=0, bubble_err=0. Reset asserted mid-window aborts with no data_valid.
- Start accepted on edge E0. SYNC covers E1, E2. Samples are accumulated at E3 … E(2+2^AVG_LOG2).
- data_valid is high for exactly one cycle after edge E(2+2^AVG_LOG2). This is E6 at the default, and data_out updates on that same edge.
- Continuous mode: subsequent strobes come every 2^AVG_LOG2 cycles, with no SYNC re-entry.
- busy rises after E0. It falls after the final edge of the last window (same edge as the final data_valid).
- Input-to-sample latency: 2 cycles (synchroniser).

## Structure
- Shared package adc_pkg:
  - state encoding (IDLE, SYNC, ACCUM);
  - constant for synchroniser depth (2);
  - clog2 helper function used for OUT_W.
- Sub-module adc_thermo_encoder (combinational):
  - parameter N_LEVELS;
  - input t, outputs code[OUT_W] and valid;
  - contains bubble correction and popcount.
- Top level holds the synchroniser, FSM, counter, accumulator and output registers.

## Test plan
Defaults throughout (N_LEVELS=15, AVG_LOG2=2).
- Reset: assert reset_n=0 during ACCUM → busy, data_valid, data_out, bubble_err all 0 immediately. No strobe after release.
- Static single-shot: comp_in=15'h007F, start pulse, continuous=0 → exactly one data_valid, after E6. data_out=7, bubble_err=0, busy=0 after E6.
- Truncation: drive synchronised codes 3,4,4,4 on accumulate edges → sum 15, data_out=3.
- Bubble: comp_in=15'h005F held → corrected code 6, data_out=6, bubble_err=1. It stays 1 until the next accepted start with a clean input, then clears.
- Continuous: comp_in=15'h7FFF, continuous=1 → strobes after E6, E10, E14 with data_out=15. Deassert continuous mid-window → one further strobe, then busy=0.
- Ignored start: pulse start while busy, comp_in=0 → no extra window, no timing shift, data_out=0.
